detector_sequencer: RTL and testbench

DETECTOR_SEQUENCER -- requirements
Module: detector_sequencer

---
 rtl/detector_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_detector_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_sequencer.sv
// rtl/detector_sequencer.sv - sequencer that drives an n-consecutive-1s/0s detector through one pattern
//
// Purpose:
//   On an accepted start, runs CLEAR -> SAVE -> RUN (16 cycles) -> DRAIN -> DONE.
//   It clears the detector, loads its run-length threshold, and shifts a 16-bit pattern
//   into it MSB first. It can optionally count rising edges of the detector output.
//
// Configuration:
//   DETSEQ_HIT_COUNT_EN - when defined, the z_q register and the hit counter are built.
//                         When undefined, hit_count is constant 0.
//
// Ports:
//   clk        in   1   rising-edge system clock
//   rst        in   1   synchronous active-high reset
//   start      in   1   request to run one sequence (only honoured in IDLE)
//   pattern    in  16   serial bit pattern, sent MSB first
//   n_cfg      in   4   run-length threshold (0 is clamped to 1)
//   det_z      in   1   detector output (run length reached)
//   det_rst    out  1   detector synchronous reset (CLEAR)
//   det_save   out  1   detector threshold-load strobe (SAVE)
//   det_n      out  4   threshold presented to the detector
//   det_w      out  1   serial data bit to the detector
//   busy       out  1   high in CLEAR, SAVE, RUN and DRAIN
//   done       out  1   one-cycle end-of-sequence pulse
//   bit_idx    out  4   index of the bit currently on det_w (0 = MSB)
//   hit_count  out  4   number of det_z rising edges in the last sequence

module detector_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pattern,
  input  logic [3:0]  n_cfg,
  input  logic        det_z,
  output logic        det_rst,
  output logic        det_save,
  output logic [3:0]  det_n,
  output logic        det_w,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bit_idx,
  output logic [3:0]  hit_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SAVE  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state;

  // The start request and its operands are registered before the FSM acts on them.
  // As a result, no output has a combinational path from an input.
  // The request is only latched while the FSM is idle, so a start seen in any other
  // state is dropped.
  logic        start_q;
  logic [15:0] pattern_q;
  logic [3:0]  n_q;

  logic [15:0] pat_reg;
  logic [3:0]  n_reg;

  assign det_n = n_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      pattern_q <= '0;
      n_q       <= '0;
      pat_reg   <= '0;
      n_reg     <= '0;
      bit_idx   <= '0;
      det_rst   <= 1'b0;
      det_save  <= 1'b0;
      det_w     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      start_q <= start && (state == IDLE);
      if (start && (state == IDLE)) begin
        pattern_q <= pattern;
        n_q       <= n_cfg;
      end

      // Strobes default low; each is raised only on entry to its own state.
      det_rst  <= 1'b0;
      det_save <= 1'b0;
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (start_q) begin
            pat_reg <= pattern_q;
            n_reg   <= (n_q == 4'd0) ? 4'd1 : n_q;
            bit_idx <= 4'd0;
            det_rst <= 1'b1;
            busy    <= 1'b1;
            state   <= CLEAR;
          end
        end

        CLEAR: begin
          det_save <= 1'b1;
          state    <= SAVE;
        end

        SAVE: begin
          det_w <= pat_reg[15];
          state <= RUN;
        end

        RUN: begin
          // The last bit stays on det_w through DRAIN.
          // This covers the detector's one-cycle output latency.
          if (bit_idx == 4'd15) begin
            state <= DRAIN;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            pat_reg <= pat_reg << 1;
            det_w   <= pat_reg[14];
          end
        end

        DRAIN: begin
          det_w <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DETSEQ_HIT_COUNT_EN
  logic       z_q;
  logic [3:0] hit_q;

  // The detector's z for the bit shown in RUN cycle i arrives in RUN cycle i+1.
  // For the last bit it arrives in DRAIN.
  // Counting rising edges across RUN and DRAIN therefore covers all 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q   <= 1'b0;
      hit_q <= '0;
    end else begin
      if (state == CLEAR) begin
        z_q <= 1'b0;
      end else begin
        z_q <= det_z;
      end

      if ((state == IDLE) && start_q) begin
        hit_q <= '0;
      end else if (((state == RUN) || (state == DRAIN)) && det_z && !z_q &&
                   (hit_q != 4'hF)) begin
        hit_q <= hit_q + 4'd1;
      end
    end
  end

  assign hit_count = hit_q;
`else
  logic unused_det_z;

  assign unused_det_z = det_z;
  assign hit_count    = '0;
`endif

endmodule

// File: tb/tb_detector_sequencer.sv
// tb/tb_detector_sequencer.sv - scoreboard bench for detector_sequencer with a behavioural detector

module tb_detector_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pattern = 16'h0000;
  logic [3:0]  n_cfg = 4'd0;
  logic        det_z;
  logic        det_rst;
  logic        det_save;
  logic [3:0]  det_n;
  logic        det_w;
  logic        busy;
  logic        done;
  logic [3:0]  bit_idx;
  logic [3:0]  hit_count;

  always #5 clk = ~clk;

  detector_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .n_cfg     (n_cfg),
    .det_z     (det_z),
    .det_rst   (det_rst),
    .det_save  (det_save),
    .det_n     (det_n),
    .det_w     (det_w),
    .busy      (busy),
    .done      (done),
    .bit_idx   (bit_idx),
    .hit_count (hit_count)
  );

  // Detector for n consecutive equal bits, with a registered z output.
  logic [3:0] d_cnt = 4'd0;
  logic [3:0] d_n = 4'd1;
  logic       d_last = 1'b0;
  logic       d_z = 1'b0;

  assign det_z = d_z;

  function automatic logic [3:0] next_run(input logic [3:0] c, input logic l, input logic w);
    if (c == 4'd0 || w != l) return 4'd1;
    if (c == 4'd15) return 4'd15;
    return c + 4'd1;
  endfunction

  always @(posedge clk) begin
    if (rst || det_rst) begin
      d_cnt  <= 4'd0;
      d_z    <= 1'b0;
      d_last <= 1'b0;
    end else if (det_save) begin
      d_n   <= det_n;
      d_cnt <= 4'd0;
      d_z   <= 1'b0;
    end else begin
      d_cnt  <= next_run(d_cnt, d_last, det_w);
      d_last <= det_w;
      d_z    <= (next_run(d_cnt, d_last, det_w) >= d_n);
    end
  end

  int   cyc = 0;
  logic rst_hit = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_hit <= rst;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] pat;
    logic [3:0]  n;
    logic [3:0]  hits;
    int          k;
    bit          abort;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   ph = 0;
  int   ri = 0;

  // Monitor: the sequence is observed through det_rst, then det_save, then 16 RUN bits,
  // then DRAIN, DONE and the following idle cycle.
  always @(negedge clk) begin
    if (rst_hit) begin
      if (ph != 0) begin
        chk("abort_expected", 32'(cur.abort), 32'd1);
        ph = 0;
      end
      chk("rst_outputs", 32'({det_rst, det_save, det_w, busy, done, det_n, bit_idx, hit_count}), 32'd0);
    end else begin
      case (ph)
        0: begin
          if (done === 1'b1) chk("spurious_done", 32'(done), 32'd0);
          if (det_rst === 1'b1) begin
            if (q.size() == 0) begin
              chk("unexpected_sequence", 32'(det_rst), 32'd0);
            end else begin
              cur = q.pop_front();
              chk("clear_time", 32'(cyc), 32'(cur.k + 1));
              chk("clear_busy", 32'({busy, det_save, done}), 32'b100);
              ph = 1;
            end
          end
        end
        1: begin
          chk("save_strobe", 32'({det_save, det_rst, busy}), 32'b101);
          chk("save_n", 32'(det_n), 32'(cur.n));
          ri = 0;
          ph = 2;
        end
        2: begin
          chk("run_w", 32'(det_w), 32'(cur.pat[15 - ri]));
          chk("run_idx", 32'(bit_idx), 32'(ri));
          chk("run_n", 32'(det_n), 32'(cur.n));
          chk("run_flags", 32'({busy, det_save, det_rst, done}), 32'b1000);
          ri++;
          if (ri == 16) ph = 3;
        end
        3: begin
          chk("drain_w", 32'(det_w), 32'(cur.pat[0]));
          chk("drain_flags", 32'({busy, done, bit_idx}), 32'({2'b10, 4'd15}));
          ph = 4;
        end
        4: begin
          chk("done_flags", 32'({done, busy}), 32'b10);
          chk("done_time", 32'(cyc), 32'(cur.k + 20));
          chk("done_hits", 32'(hit_count), 32'(cur.hits));
          chk("done_idx", 32'(bit_idx), 32'd15);
          ph = 5;
        end
        default: begin
          chk("post_flags", 32'({done, busy}), 32'b00);
          chk("post_hits_hold", 32'(hit_count), 32'(cur.hits));
          ph = 0;
        end
      endcase
    end
  end

  function automatic logic [3:0] hsel(input logic [3:0] h);
`ifdef DETSEQ_HIT_COUNT_EN
    return h;
`else
    return (h & 4'd0);
`endif
  endfunction

  task automatic do_seq(input logic [15:0] p, input logic [3:0] n, input logic [3:0] exp_n,
                        input logic [3:0] hits, input bit abort);
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    pattern = p;
    n_cfg   = n;
    e.pat   = p;
    e.n     = exp_n;
    e.hits  = hits;
    e.k     = cyc + 1;
    e.abort = abort;
    q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    pattern = ~p;
    n_cfg   = 4'd9;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("timeout_done", 32'(done), 32'd1);
  endtask

  task automatic wait_idx(input logic [3:0] v);
    int t = 0;
    while (!(busy === 1'b1 && bit_idx === v) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("timeout_idx", 32'(bit_idx), 32'(v));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_seq(16'hFFFF, 4'd3, 4'd3, hsel(4'd1), 1'b0);
    wait_done();
    do_seq(16'hF0F0, 4'd4, 4'd4, hsel(4'd4), 1'b0);
    wait_done();
    do_seq(16'hAAAA, 4'd2, 4'd2, 4'd0, 1'b0);
    wait_done();
    do_seq(16'h0000, 4'd0, 4'd1, hsel(4'd1), 1'b0);
    wait_done();

    // A start during RUN carries a different pattern and must not disturb the sequence.
    do_seq(16'h3C5A, 4'd2, 4'd2, hsel(4'd4), 1'b0);
    wait_idx(4'd5);
    @(negedge clk);
    start   = 1'b1;
    pattern = 16'h1234;
    n_cfg   = 4'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (25) @(negedge clk);

    // Reset arrives mid-RUN together with start. Reset wins and no done may follow.
    do_seq(16'hFFFF, 4'd1, 4'd1, 4'd0, 1'b1);
    wait_idx(4'd7);
    rst     = 1'b1;
    start   = 1'b1;
    pattern = 16'h5555;
    n_cfg   = 4'd5;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (25) @(negedge clk);

    do_seq(16'h8001, 4'd14, 4'd14, hsel(4'd1), 1'b0);
    wait_done();
    repeat (5) @(negedge clk);

    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("monitor_idle", 32'(ph), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
